// File: rtl/exe_mt.sv
// exe_mt: multithreaded execute stage with per-thread MEM/WB forwarding, load-use stall
// and the EXE/MEM pipeline register. Define EXE_MUL_EN to build the shift-add multiplier.
module exe_mt #(
   parameter int XLEN  = 32,
   parameter int TRD_W = 3,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_exe,
   input  logic [TRD_W-1:0] trd_exe,
   input  logic [REG_W-1:0] rs_a,
   input  logic [REG_W-1:0] rs_b,
   input  logic [REG_W-1:0] rd,
   input  logic             wr_en_exe,
   input  logic             ld_exe,
   input  logic [XLEN-1:0]  data_a,
   input  logic [XLEN-1:0]  data_b,
   input  logic [15:0]      imm,
   input  logic             i_type,
   input  logic [2:0]       alu_op,
   input  logic [TRD_W-1:0] trd_wb,
   input  logic [REG_W-1:0] rd_wb,
   input  logic             wr_en_wb,
   input  logic [XLEN-1:0]  data_wb,
   input  logic             flush,
   input  logic             stall_in,
   output logic             valid_mem,
   output logic [TRD_W-1:0] trd_mem,
   output logic [REG_W-1:0] rd_mem,
   output logic             wr_en_mem,
   output logic             ld_mem,
   output logic [XLEN-1:0]  res_mem,
   output logic             of_mem,
   output logic             stall_exe,
   output logic             illegal_exe
);

   localparam int SH_W = $clog2(XLEN);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   logic             valid_mem_q, valid_mem_d;
   logic [TRD_W-1:0] trd_mem_q, trd_mem_d;
   logic [REG_W-1:0] rd_mem_q, rd_mem_d;
   logic             wr_en_mem_q, wr_en_mem_d;
   logic             ld_mem_q, ld_mem_d;
   logic [XLEN-1:0]  res_mem_q, res_mem_d;
   logic             of_mem_q, of_mem_d;
   logic             illegal_q, illegal_d;

   logic             fwd_mem_a_s, fwd_mem_b_s, fwd_wb_a_s, fwd_wb_b_s;
   logic             load_use_s, stall_exe_s, illegal_op_s, mul_done_s;
   logic [XLEN-1:0]  op_a_s, op_b_s, alu_s, mul_res_s;
   logic             of_s;

   // Operand selection: a MEM-stage result beats the WB bypass, which beats the register file
   always_comb begin
      fwd_mem_a_s = valid_mem_q & wr_en_mem_q & (trd_mem_q == trd_exe) & (rd_mem_q == rs_a)
                    & (rs_a != {REG_W{1'b0}});
      fwd_mem_b_s = valid_mem_q & wr_en_mem_q & (trd_mem_q == trd_exe) & (rd_mem_q == rs_b)
                    & (rs_b != {REG_W{1'b0}});
      fwd_wb_a_s  = wr_en_wb & (trd_wb == trd_exe) & (rd_wb == rs_a) & (rs_a != {REG_W{1'b0}});
      fwd_wb_b_s  = wr_en_wb & (trd_wb == trd_exe) & (rd_wb == rs_b) & (rs_b != {REG_W{1'b0}});
      if (fwd_mem_a_s) begin
         op_a_s = res_mem_q;
      end else if (fwd_wb_a_s) begin
         op_a_s = data_wb;
      end else begin
         op_a_s = data_a;
      end
      if (i_type) begin
         op_b_s = XLEN'($signed(imm));
      end else if (fwd_mem_b_s) begin
         op_b_s = res_mem_q;
      end else if (fwd_wb_b_s) begin
         op_b_s = data_wb;
      end else begin
         op_b_s = data_b;
      end
      // a load's MEM result is only an address, so its consumer must wait one cycle
      load_use_s = valid_exe & ld_mem_q & (fwd_mem_a_s | fwd_mem_b_s);
   end

   // Single-cycle ALU; overflow is reported for ADD/SUB only
   always_comb begin
      alu_s = {XLEN{1'b0}};
      of_s  = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_s = op_a_s + op_b_s;
            of_s  = (op_a_s[XLEN-1] == op_b_s[XLEN-1]) & (alu_s[XLEN-1] != op_a_s[XLEN-1]);
         end
         OP_SUB: begin
            alu_s = op_a_s - op_b_s;
            of_s  = (op_a_s[XLEN-1] != op_b_s[XLEN-1]) & (alu_s[XLEN-1] != op_a_s[XLEN-1]);
         end
         OP_AND:  alu_s = op_a_s & op_b_s;
         OP_OR:   alu_s = op_a_s | op_b_s;
         OP_XOR:  alu_s = op_a_s ^ op_b_s;
         OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
         OP_SLL:  alu_s = op_a_s << op_b_s[SH_W-1:0];
         default: alu_s = {XLEN{1'b0}};
      endcase
   end

`ifdef EXE_MUL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   mul_state_e      state_q, state_d;
   logic [SH_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic            start_s;

   // Multiplier state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= {SH_W{1'b0}};
         mcand_q  <= {XLEN{1'b0}};
         mplier_q <= {XLEN{1'b0}};
         acc_q    <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   // Shift-add sequencing: one multiplier bit per BUSY cycle, counter runs XLEN-1 down to 0
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      start_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_exe && (alu_op == OP_MUL) && !load_use_s && !flush && !stall_in) begin
               start_s  = 1'b1;
               state_d  = BUSY;
               cnt_d    = SH_W'(XLEN - 1);
               mcand_d  = op_a_s;
               mplier_d = op_b_s;
               acc_d    = {XLEN{1'b0}};
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end else begin
                  acc_d = acc_q;
               end
               mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
               mplier_d = {1'b0, mplier_q[XLEN-1:1]};
               if (cnt_q == {SH_W{1'b0}}) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q - 1'b1;
               end
            end
         end
         DONE: begin
            if (flush || !stall_in) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall_exe_s  = (state_q == BUSY) | ((state_q == IDLE) & (load_use_s | start_s));
   assign mul_done_s   = (state_q == DONE);
   assign mul_res_s    = acc_q;
   assign illegal_op_s = 1'b0;
`else
   assign stall_exe_s  = load_use_s;
   assign mul_done_s   = 1'b0;
   assign mul_res_s    = {XLEN{1'b0}};
   assign illegal_op_s = valid_exe & (alu_op == OP_MUL);
`endif

   // EXE/MEM register next state: flush, then downstream hold, then own stall, then capture
   always_comb begin
      valid_mem_d = valid_mem_q;
      trd_mem_d   = trd_mem_q;
      rd_mem_d    = rd_mem_q;
      wr_en_mem_d = wr_en_mem_q;
      ld_mem_d    = ld_mem_q;
      res_mem_d   = res_mem_q;
      of_mem_d    = of_mem_q;
      illegal_d   = 1'b0;
      if (flush) begin
         valid_mem_d = 1'b0;
         wr_en_mem_d = 1'b0;
         ld_mem_d    = 1'b0;
      end else if (stall_in) begin
         valid_mem_d = valid_mem_q;
      end else if (stall_exe_s) begin
         valid_mem_d = 1'b0;
         wr_en_mem_d = 1'b0;
         ld_mem_d    = 1'b0;
      end else begin
         valid_mem_d = valid_exe;
         trd_mem_d   = trd_exe;
         rd_mem_d    = rd;
         wr_en_mem_d = valid_exe & wr_en_exe & ~illegal_op_s;
         ld_mem_d    = valid_exe & ld_exe;
         of_mem_d    = valid_exe & of_s;
         illegal_d   = illegal_op_s;
         if (illegal_op_s) begin
            res_mem_d = {XLEN{1'b0}};
         end else if (mul_done_s) begin
            res_mem_d = mul_res_s;
         end else begin
            res_mem_d = alu_s;
         end
      end
   end

   // EXE/MEM register and the registered illegal-op pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_mem_q <= 1'b0;
         trd_mem_q   <= {TRD_W{1'b0}};
         rd_mem_q    <= {REG_W{1'b0}};
         wr_en_mem_q <= 1'b0;
         ld_mem_q    <= 1'b0;
         res_mem_q   <= {XLEN{1'b0}};
         of_mem_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         valid_mem_q <= valid_mem_d;
         trd_mem_q   <= trd_mem_d;
         rd_mem_q    <= rd_mem_d;
         wr_en_mem_q <= wr_en_mem_d;
         ld_mem_q    <= ld_mem_d;
         res_mem_q   <= res_mem_d;
         of_mem_q    <= of_mem_d;
         illegal_q   <= illegal_d;
      end
   end

   assign valid_mem   = valid_mem_q;
   assign trd_mem     = trd_mem_q;
   assign rd_mem      = rd_mem_q;
   assign wr_en_mem   = wr_en_mem_q;
   assign ld_mem      = ld_mem_q;
   assign res_mem     = res_mem_q;
   assign of_mem      = of_mem_q;
   assign stall_exe   = stall_exe_s;
   assign illegal_exe = illegal_q;

endmodule

// File: tb/tb_exe_mt.sv
// tb_exe_mt: vector table, hand-written forwarding/stall/flush sequences and a randomized
// run of exe_mt (XLEN=32) against a behavioural model of the execute stage.
`timescale 1ns/1ps
module tb_exe_mt;
   localparam int XLEN  = 32;
   localparam int TRD_W = 3;
   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             valid_exe, wr_en_exe, ld_exe, i_type, wr_en_wb, flush, stall_in;
   logic [TRD_W-1:0] trd_exe, trd_wb;
   logic [REG_W-1:0] rs_a, rs_b, rd, rd_wb;
   logic [XLEN-1:0]  data_a, data_b, data_wb;
   logic [15:0]      imm;
   logic [2:0]       alu_op;
   logic             valid_mem, wr_en_mem, ld_mem, of_mem, stall_exe, illegal_exe;
   logic [TRD_W-1:0] trd_mem;
   logic [REG_W-1:0] rd_mem;
   logic [XLEN-1:0]  res_mem;

   always #5 clk = ~clk;

   exe_mt #(.XLEN(XLEN), .TRD_W(TRD_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst_n(rst_n), .valid_exe(valid_exe), .trd_exe(trd_exe), .rs_a(rs_a),
      .rs_b(rs_b), .rd(rd), .wr_en_exe(wr_en_exe), .ld_exe(ld_exe), .data_a(data_a),
      .data_b(data_b), .imm(imm), .i_type(i_type), .alu_op(alu_op), .trd_wb(trd_wb),
      .rd_wb(rd_wb), .wr_en_wb(wr_en_wb), .data_wb(data_wb), .flush(flush),
      .stall_in(stall_in), .valid_mem(valid_mem), .trd_mem(trd_mem), .rd_mem(rd_mem),
      .wr_en_mem(wr_en_mem), .ld_mem(ld_mem), .res_mem(res_mem), .of_mem(of_mem),
      .stall_exe(stall_exe), .illegal_exe(illegal_exe)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      valid_exe = 1'b0; wr_en_exe = 1'b0; ld_exe = 1'b0; i_type = 1'b0;
      wr_en_wb = 1'b0; flush = 1'b0; stall_in = 1'b0;
      trd_exe = '0; trd_wb = '0; rs_a = '0; rs_b = '0; rd = '0; rd_wb = '0;
      data_a = '0; data_b = '0; data_wb = '0; imm = '0; alu_op = '0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] trd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] rdd, input logic [31:0] da,
                        input logic [31:0] db, input logic wr, input logic ld);
      valid_exe = 1'b1; alu_op = op; trd_exe = trd; rs_a = ra; rs_b = rb; rd = rdd;
      data_a = da; data_b = db; wr_en_exe = wr; ld_exe = ld;
      i_type = 1'b0; imm = 16'd0; flush = 1'b0; stall_in = 1'b0;
   endtask

   // Reference arithmetic straight from the opcode definitions
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return a << sh;
`ifdef EXE_MUL_EN
         3'd7: return a * b;
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_of(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
      longint s;
      if (op == 3'd0) s = longint'($signed(a)) + longint'($signed(b));
      else if (op == 3'd1) s = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Model of the EXE/MEM register contents
   logic        m_valid, m_wr, m_ld, m_of, m_ill;
   logic [2:0]  m_trd;
   logic [4:0]  m_rd;
   logic [31:0] m_res;

   function automatic logic mem_hit(input logic [4:0] rs);
      return (rs != 5'd0) && m_valid && m_wr && (m_trd == trd_exe) && (m_rd == rs);
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
      if (mem_hit(rs)) return m_res;
      if ((rs != 5'd0) && wr_en_wb && (trd_wb == trd_exe) && (rd_wb == rs)) return data_wb;
      return rf;
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic        it;
      logic [31:0] res;
      logic        of;
      logic        ill;
   } vec_t;

   vec_t vt[14];
   int   n_vec;
   int   n_st;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{3'd0, 32'h7FFFFFFF, 32'd1,        16'h0000, 1'b0, 32'h80000000, 1'b1, 1'b0};
      vt[1]  = '{3'd0, 32'd5,        32'd3,        16'h0000, 1'b0, 32'd8,        1'b0, 1'b0};
      vt[2]  = '{3'd1, 32'd3,        32'd5,        16'h0000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
      vt[3]  = '{3'd1, 32'h80000000, 32'd1,        16'h0000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0};
      vt[4]  = '{3'd2, 32'h0000F0F0, 32'h0000FF00, 16'h0000, 1'b0, 32'h0000F000, 1'b0, 1'b0};
      vt[5]  = '{3'd3, 32'h0000F0F0, 32'h00000F00, 16'h0000, 1'b0, 32'h0000FFF0, 1'b0, 1'b0};
      vt[6]  = '{3'd4, 32'h000000FF, 32'h0000000F, 16'h0000, 1'b0, 32'h000000F0, 1'b0, 1'b0};
      vt[7]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        16'h0000, 1'b0, 32'd1,        1'b0, 1'b0};
      vt[8]  = '{3'd5, 32'd1,        32'hFFFFFFFF, 16'h0000, 1'b0, 32'd0,        1'b0, 1'b0};
      vt[9]  = '{3'd6, 32'd1,        32'd31,       16'h0000, 1'b0, 32'h80000000, 1'b0, 1'b0};
      vt[10] = '{3'd6, 32'd3,        32'd36,       16'h0000, 1'b0, 32'h00000030, 1'b0, 1'b0};
      vt[11] = '{3'd0, 32'd10,       32'hDEAD,     16'hFFFF, 1'b1, 32'd9,        1'b0, 1'b0};
      vt[12] = '{3'd0, 32'd1,        32'hDEAD,     16'h7FFF, 1'b1, 32'h00008000, 1'b0, 1'b0};
      vt[13] = '{3'd7, 32'd3,        32'd4,        16'h0000, 1'b0, 32'd0,        1'b0, 1'b1};
`ifdef EXE_MUL_EN
      n_vec = 13;
`else
      n_vec = 14;
`endif

      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_mem", 64'(valid_mem), 64'd0);
      chk("rst_wr_en_mem", 64'(wr_en_mem), 64'd0);
      chk("rst_ld_mem", 64'(ld_mem), 64'd0);
      chk("rst_res_mem", 64'(res_mem), 64'd0);
      chk("rst_trd_rd", 64'({trd_mem, rd_mem}), 64'd0);
      chk("rst_of_mem", 64'(of_mem), 64'd0);
      chk("rst_illegal", 64'(illegal_exe), 64'd0);
      chk("rst_stall", 64'(stall_exe), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < n_vec; i++) begin
         issue(vt[i].op, 3'd1, 5'd1, 5'd2, 5'd5, vt[i].a, vt[i].b, 1'b1, 1'b0);
         imm = vt[i].imm;
         i_type = vt[i].it;
         settle();
         chk($sformatf("vec%0d_stall", i), 64'(stall_exe), 64'd0);
         tick();
         chk($sformatf("vec%0d_res", i), 64'(res_mem), 64'(vt[i].res));
         chk($sformatf("vec%0d_of", i), 64'(of_mem), 64'(vt[i].of));
         chk($sformatf("vec%0d_wr", i), 64'(wr_en_mem), 64'(!vt[i].ill));
         chk($sformatf("vec%0d_ill", i), 64'(illegal_exe), 64'(vt[i].ill));
         chk($sformatf("vec%0d_valid", i), 64'(valid_mem), 64'd1);
      end

      // MEM forwarding, same thread
      issue(3'd0, 3'd2, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0);
      i_type = 1'b1; imm = 16'h0010;
      tick();
      issue(3'd0, 3'd2, 5'd3, 5'd6, 5'd7, 32'hDEAD, 32'd5, 1'b1, 1'b0);
      tick();
      chk("fwd_mem", 64'(res_mem), 64'h15);

      // MEM belongs to another thread, so the WB bypass wins
      issue(3'd0, 3'd1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 1'b1, 1'b0);
      i_type = 1'b1; imm = 16'h0010;
      tick();
      issue(3'd0, 3'd2, 5'd3, 5'd6, 5'd7, 32'hDEAD, 32'd5, 1'b1, 1'b0);
      wr_en_wb = 1'b1; trd_wb = 3'd2; rd_wb = 5'd3; data_wb = 32'h20;
      tick();
      chk("fwd_wb", 64'(res_mem), 64'h25);
      wr_en_wb = 1'b0;

      // Load-use: one bubble, then the retry picks up WB data
      issue(3'd0, 3'd0, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 1'b1, 1'b1);
      i_type = 1'b1; imm = 16'h0040;
      tick();
      chk("ld_setup", 64'({valid_mem, ld_mem}), 64'd3);
      issue(3'd0, 3'd0, 5'd0, 5'd4, 5'd8, 32'd1, 32'hBAD, 1'b1, 1'b0);
      settle();
      chk("lu_stall", 64'(stall_exe), 64'd1);
      tick();
      chk("lu_bubble", 64'({valid_mem, wr_en_mem}), 64'd0);
      wr_en_wb = 1'b1; trd_wb = 3'd0; rd_wb = 5'd4; data_wb = 32'h100;
      settle();
      chk("lu_retry_stall", 64'(stall_exe), 64'd0);
      tick();
      chk("lu_retry_res", 64'(res_mem), 64'h101);
      chk("lu_retry_valid", 64'(valid_mem), 64'd1);
      wr_en_wb = 1'b0;

      // Register 0 is never forwarded
      issue(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      i_type = 1'b1; imm = 16'h0055;
      tick();
      issue(3'd0, 3'd0, 5'd0, 5'd0, 5'd9, 32'd7, 32'd8, 1'b1, 1'b0);
      tick();
      chk("r0_no_fwd", 64'(res_mem), 64'd15);

`ifndef EXE_MUL_EN
      // Opcode 7 without a multiplier: one-cycle illegal pulse, no write, no stall
      issue(3'd7, 3'd0, 5'd1, 5'd2, 5'd6, 32'd3, 32'd4, 1'b1, 1'b0);
      settle();
      chk("ill_stall", 64'(stall_exe), 64'd0);
      tick();
      chk("ill_pulse", 64'({illegal_exe, wr_en_mem}), 64'b10);
      chk("ill_res", 64'(res_mem), 64'd0);
      idle();
      tick();
      chk("ill_pulse_end", 64'(illegal_exe), 64'd0);
`endif

      // flush squashes; stall_in holds the register
      issue(3'd0, 3'd0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      chk("flush_bubble", 64'({valid_mem, wr_en_mem}), 64'd0);
      issue(3'd0, 3'd0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, 1'b1, 1'b0);
      tick();
      chk("hold_pre", 64'(res_mem), 64'd3);
      issue(3'd0, 3'd0, 5'd1, 5'd2, 5'd6, 32'd10, 32'd20, 1'b1, 1'b0);
      stall_in = 1'b1;
      tick();
      chk("hold_res", 64'({valid_mem, res_mem}), {31'd0, 1'b1, 32'd3});
      stall_in = 1'b0;
      tick();
      chk("hold_release", 64'(res_mem), 64'd30);

`ifdef EXE_MUL_EN
      idle();
      tick();
      issue(3'd7, 3'd0, 5'd1, 5'd2, 5'd9, 32'd7, 32'd9, 1'b1, 1'b0);
      n_st = 0;
      for (int c = 0; c < 40; c++) begin
         settle();
         if (!stall_exe) break;
         n_st++;
         tick();
      end
      chk("mul_stall_cycles", 64'(n_st), 64'd33);
      tick();
      chk("mul_res", 64'(res_mem), 64'd63);
      chk("mul_valid_wr", 64'({valid_mem, wr_en_mem}), 64'b11);
      idle();
      tick();
      issue(3'd7, 3'd0, 5'd1, 5'd2, 5'd9, 32'd7, 32'd9, 1'b1, 1'b0);
      repeat (10) tick();
      settle();
      chk("mul_busy10_stall", 64'(stall_exe), 64'd1);
      flush = 1'b1; valid_exe = 1'b0;
      tick();
      chk("mul_flush_bubble", 64'({valid_mem, wr_en_mem}), 64'd0);
      flush = 1'b0;
      settle();
      chk("mul_flush_idle", 64'(stall_exe), 64'd0);
      tick();
      chk("mul_flush_nowrite", 64'(valid_mem), 64'd0);
`endif

      // Randomized run against the model; a flush first puts the register in a known bubble
      idle();
      flush = 1'b1;
      tick();
      m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0; m_of = 1'b0; m_ill = 1'b0;
      m_trd = 3'd0; m_rd = 5'd0; m_res = 32'd0;
      for (int i = 0; i < 500; i++) begin
         logic        lu, cap;
         logic [31:0] fa, fb;
         valid_exe = ($urandom_range(0, 9) != 0);
         trd_exe   = 3'($urandom_range(0, 1));
         rs_a      = 5'($urandom_range(0, 3));
         rs_b      = 5'($urandom_range(0, 3));
         rd        = 5'($urandom_range(0, 3));
         wr_en_exe = ($urandom_range(0, 3) != 0);
         ld_exe    = ($urandom_range(0, 3) == 0);
         data_a    = $urandom;
         data_b    = $urandom;
         imm       = 16'($urandom);
         i_type    = ($urandom_range(0, 3) == 0);
`ifdef EXE_MUL_EN
         alu_op    = 3'($urandom_range(0, 6));
`else
         alu_op    = 3'($urandom_range(0, 7));
`endif
         trd_wb    = 3'($urandom_range(0, 1));
         rd_wb     = 5'($urandom_range(0, 3));
         wr_en_wb  = ($urandom_range(0, 1) != 0);
         data_wb   = $urandom;
         flush     = ($urandom_range(0, 15) == 0);
         stall_in  = ($urandom_range(0, 7) == 0);

         fa = operand(rs_a, data_a);
         fb = i_type ? {{16{imm[15]}}, imm} : operand(rs_b, data_b);
         lu = valid_exe && m_ld && (mem_hit(rs_a) || mem_hit(rs_b));
         settle();
         chk($sformatf("rnd%0d_stall", i), 64'(stall_exe), 64'(lu));

         cap = 1'b0;
         if (flush || (!stall_in && lu)) begin
            m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0;
         end else if (!stall_in) begin
            cap     = 1'b1;
            m_valid = valid_exe;
            m_wr    = valid_exe && wr_en_exe && (alu_op != 3'd7);
            m_ld    = valid_exe && ld_exe;
            m_trd   = trd_exe;
            m_rd    = rd;
            m_res   = ref_res(alu_op, fa, fb);
            m_of    = ref_of(alu_op, fa, fb);
         end
         m_ill = cap && valid_exe && (alu_op == 3'd7);
         tick();
         chk($sformatf("rnd%0d_valid_wr", i), 64'({valid_mem, wr_en_mem}), 64'({m_valid, m_wr}));
         chk($sformatf("rnd%0d_ill", i), 64'(illegal_exe), 64'(m_ill));
         if (m_valid) begin
            chk($sformatf("rnd%0d_res", i), 64'(res_mem), 64'(m_res));
            chk($sformatf("rnd%0d_fields", i), 64'({trd_mem, rd_mem, ld_mem, of_mem}),
                64'({m_trd, m_rd, m_ld, m_of}));
         end
      end

      // Asynchronous reset clears the register mid-cycle
      idle();
      issue(3'd0, 3'd0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 1'b1, 1'b0);
      tick();
      chk("pre_async_rst", 64'(valid_mem), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem", 64'({valid_mem, wr_en_mem, res_mem}), 64'd0);
      chk("async_rst_ill", 64'(illegal_exe), 64'd0);
      idle();
      tick();
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
